// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the generated SRAM primitives.
`ifndef MEM_PKG_SV
`define MEM_PKG_SV

// Elaboration-time guard: the named block is only generated when cond fails.
`define MEM_ELAB_CHECK(cond, label, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  // Address width for n words, never narrower than one bit.
  function automatic int mem_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int mem_seg_count(input int width, input int gran);
    return width / gran;
  endfunction

  function automatic int mem_seg_lo(input int seg, input int gran);
    return seg * gran;
  endfunction

endpackage

`endif

// File: rtl/sram_rw_masked_ext_if.sv
// Single-port request/response bundle between an array user and the SRAM.
// Handshake: a request is taken on any posedge where en=1 and ready=1; rvalid
// is a one-cycle pulse per accepted read, in request order; no backpressure.
interface sram_rw_masked_ext_if #(
  parameter int ADDR_W   = 7,
  parameter int WIDTH    = 81,
  parameter int MASK_SEG = 1
);
  import mem_pkg::*;

  logic [ADDR_W-1:0]   addr;
  logic                en;
  logic                wmode;
  logic [MASK_SEG-1:0] wmask;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    rdata;
  logic                rvalid;
  logic                ready;
  mem_state_e          state;

  modport master (
    output addr, en, wmode, wmask, wdata,
    input  rdata, rvalid, ready, state
  );

  modport slave (
    input  addr, en, wmode, wmask, wdata,
    output rdata, rvalid, ready, state
  );
endinterface

// File: rtl/sram_rw_masked_core.sv
// Bare storage array: per-segment masked write and a registered read port.
module sram_rw_masked_core
  import mem_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int WIDTH     = 81,
  parameter int MASK_GRAN = 81,
  parameter int ADDR_W    = 7,
  localparam int MASK_SEG = mem_seg_count(WIDTH, MASK_GRAN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic                rd_zero,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [MASK_SEG-1:0] wmask,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int s = 0; s < MASK_SEG; s++) begin
        if (wmask[s]) begin
          mem_q[addr][mem_seg_lo(s, MASK_GRAN) +: MASK_GRAN] <=
            wdata[mem_seg_lo(s, MASK_GRAN) +: MASK_GRAN];
        end
      end
    end
  end

  // The read register only moves on an accepted read, which gives the hold behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_zero ? '0 : mem_q[addr];
    end
  end

endmodule

// File: rtl/sram_rw_masked_ext.sv
// Parametrised single-port SRAM: init sweep FSM, request gating, out-of-range
// handling and an optional output register around the storage core.
module sram_rw_masked_ext
  import mem_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int WIDTH     = 81,
  parameter int MASK_GRAN = 81,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1,
  localparam int ADDR_W   = mem_clog2(DEPTH),
  localparam int MASK_SEG = mem_seg_count(WIDTH, MASK_GRAN)
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst_n,
  sram_rw_masked_ext_if.slave   rw0
);

  `MEM_ELAB_CHECK((WIDTH % MASK_GRAN) == 0, g_chk_mask_gran, "WIDTH must be a multiple of MASK_GRAN")
  `MEM_ELAB_CHECK(DEPTH >= 2, g_chk_depth, "DEPTH must be at least 2")

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam mem_state_e RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

  mem_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q;
  logic                rv1_q;
  logic                init_we;
  logic                in_range;
  logic                rd_acc;
  logic                wr_acc;
  logic                core_we;
  logic [ADDR_W-1:0]   core_addr;
  logic [MASK_SEG-1:0] core_wmask;
  logic [WIDTH-1:0]    core_wdata;
  logic [WIDTH-1:0]    core_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // ready is registered from the next state so it stays low through reset
  // even when the array skips the sweep.
  always_ff @(posedge RW0_clk) begin
    if (!RW0_rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_READY);
      rv1_q   <= rd_acc;
    end
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    assign in_range = ({1'b0, rw0.addr} < DEPTH_L);
  end

  assign rd_acc     = RW0_rst_n & ready_q & rw0.en & ~rw0.wmode;
  assign wr_acc     = RW0_rst_n & ready_q & rw0.en & rw0.wmode & in_range;
  assign core_we    = RW0_rst_n & (init_we | wr_acc);
  assign core_addr  = init_we ? cnt_q : rw0.addr;
  assign core_wmask = init_we ? '1 : rw0.wmask;
  assign core_wdata = init_we ? '0 : rw0.wdata;

  sram_rw_masked_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .ADDR_W    (ADDR_W)
  ) u_core (
    .clk     (RW0_clk),
    .rst_n   (RW0_rst_n),
    .we      (core_we),
    .re      (rd_acc),
    .rd_zero (~in_range),
    .addr    (core_addr),
    .wmask   (core_wmask),
    .wdata   (core_wdata),
    .rdata   (core_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic             rv2_q;
    logic [WIDTH-1:0] rd2_q;

    always_ff @(posedge RW0_clk) begin
      if (!RW0_rst_n) begin
        rv2_q <= 1'b0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) rd2_q <= core_rdata;
      end
    end

    assign rw0.rvalid = rv2_q;
    assign rw0.rdata  = rd2_q;
  end else begin : g_no_out_reg
    assign rw0.rvalid = rv1_q;
    assign rw0.rdata  = core_rdata;
  end

  assign rw0.ready = ready_q;
  assign rw0.state = state_q;

endmodule

// File: tb/tb_sram_rw_masked_ext.sv
// Bench for sram_rw_masked_ext: three configurations driven from one bus,
// a cycle-level behavioural model plus a queue of hand-computed read results.
module tb_sram_rw_masked_ext;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  always #5 clk = ~clk;

  // ---------------- shared drive bus ----------------
  int          b_sel   = 0;
  logic        b_en    = 1'b0;
  logic        b_wmode = 1'b0;
  logic [6:0]  b_addr  = '0;
  logic [2:0]  b_wmask = '0;
  logic [80:0] b_wdata = '0;

  // A: 128x81, 27-bit segments, no out reg, zero init
  // B: 100x8, out reg, zero init;  C: 100x8, out reg, no init
  sram_rw_masked_ext_if #(.ADDR_W(7), .WIDTH(81), .MASK_SEG(3)) if_a ();
  sram_rw_masked_ext_if #(.ADDR_W(7), .WIDTH(8),  .MASK_SEG(1)) if_b ();
  sram_rw_masked_ext_if #(.ADDR_W(7), .WIDTH(8),  .MASK_SEG(1)) if_c ();

  assign if_a.addr  = b_addr;
  assign if_a.en    = b_en && (b_sel == 0);
  assign if_a.wmode = b_wmode;
  assign if_a.wmask = b_wmask;
  assign if_a.wdata = b_wdata;
  assign if_b.addr  = b_addr;
  assign if_b.en    = b_en && (b_sel == 1);
  assign if_b.wmode = b_wmode;
  assign if_b.wmask = b_wmask[0:0];
  assign if_b.wdata = b_wdata[7:0];
  assign if_c.addr  = b_addr;
  assign if_c.en    = b_en && (b_sel == 2);
  assign if_c.wmode = b_wmode;
  assign if_c.wmask = b_wmask[0:0];
  assign if_c.wdata = b_wdata[7:0];

  sram_rw_masked_ext #(.DEPTH(128), .WIDTH(81), .MASK_GRAN(27), .OUT_REG(0), .INIT_ZERO(1))
    dut_a (.RW0_clk(clk), .RW0_rst_n(rst_n[0]), .rw0(if_a));
  sram_rw_masked_ext #(.DEPTH(100), .WIDTH(8), .MASK_GRAN(8), .OUT_REG(1), .INIT_ZERO(1))
    dut_b (.RW0_clk(clk), .RW0_rst_n(rst_n[1]), .rw0(if_b));
  sram_rw_masked_ext #(.DEPTH(100), .WIDTH(8), .MASK_GRAN(8), .OUT_REG(1), .INIT_ZERO(0))
    dut_c (.RW0_clk(clk), .RW0_rst_n(rst_n[2]), .rw0(if_c));

  logic [80:0] rd_obs [3];
  logic        rv_obs [3];
  logic        rdy_obs [3];
  assign rd_obs[0]  = if_a.rdata;
  assign rd_obs[1]  = {73'b0, if_b.rdata};
  assign rd_obs[2]  = {73'b0, if_c.rdata};
  assign rv_obs[0]  = if_a.rvalid;
  assign rv_obs[1]  = if_b.rvalid;
  assign rv_obs[2]  = if_c.rvalid;
  assign rdy_obs[0] = if_a.ready;
  assign rdy_obs[1] = if_b.ready;
  assign rdy_obs[2] = if_c.ready;

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [80:0] act, input logic [80:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int depth_p [3] = '{128, 100, 100};
  int lat_p   [3] = '{1, 2, 2};
  int gran_p  [3] = '{27, 8, 8};
  int nseg_p  [3] = '{3, 1, 1};
  bit initz_p [3] = '{1'b1, 1'b1, 1'b0};

  logic [80:0] mem_m   [3][128];
  bit          known_m [3][128];
  int          rel     [3];      // posedges seen with reset released
  bit          pv      [3][2];   // read results in flight, by age
  logic [80:0] pd      [3][2];
  bit          pk      [3][2];
  logic [80:0] hold_m  [3];
  bit          hold_k  [3];

  function automatic bit m_ready(input int k);
    return initz_p[k] ? (rel[k] >= depth_p[k]) : (rel[k] >= 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit was_ready;
      bit en_k;
      bit inr;
      bit full;
      if (!rst_n[k]) begin
        rel[k] = 0;
        pv[k][0] = 1'b0;
        pv[k][1] = 1'b0;
        hold_m[k] = '0;
        hold_k[k] = 1'b1;
        if (initz_p[k]) begin
          for (int a = 0; a < 128; a++) begin
            mem_m[k][a]   = '0;
            known_m[k][a] = 1'b1;
          end
        end
      end else begin
        was_ready = m_ready(k);
        en_k = b_en && (b_sel == k);
        inr  = (int'(b_addr) < depth_p[k]);
        pv[k][1] = pv[k][0];
        pd[k][1] = pd[k][0];
        pk[k][1] = pk[k][0];
        pv[k][0] = was_ready && en_k && !b_wmode;
        pd[k][0] = inr ? mem_m[k][b_addr] : '0;
        pk[k][0] = inr ? known_m[k][b_addr] : 1'b1;
        if (was_ready && en_k && b_wmode && inr) begin
          full = 1'b1;
          for (int s = 0; s < nseg_p[k]; s++) begin
            if (b_wmask[s]) begin
              for (int b = 0; b < gran_p[k]; b++)
                mem_m[k][b_addr][s*gran_p[k]+b] = b_wdata[s*gran_p[k]+b];
            end else begin
              full = 1'b0;
            end
          end
          if (full) known_m[k][b_addr] = 1'b1;
        end
        if (rel[k] < 10000) rel[k]++;
        if (pv[k][lat_p[k]-1]) begin
          hold_m[k] = pd[k][lat_p[k]-1];
          hold_k[k] = pk[k][lat_p[k]-1];
        end
      end
    end
  end

  // ---------------- scoreboard of literal read results ----------------
  logic [80:0] exp_q [$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready%0d", k), 81'(rdy_obs[k]), 81'(m_ready(k)));
      check($sformatf("rvalid%0d", k), 81'(rv_obs[k]), 81'(pv[k][lat_p[k]-1]));
      if (hold_k[k]) check($sformatf("rdata%0d", k), rd_obs[k], hold_m[k]);
      if (rv_obs[k]) begin
        if (exp_q.size() == 0) check($sformatf("unexpected_rvalid%0d", k), 81'd1, 81'd0);
        else check($sformatf("rdata_lit%0d", k), rd_obs[k], exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [6:0] a, input logic [80:0] d, input logic [2:0] m);
    b_sel = k; b_en = 1'b1; b_wmode = 1'b1; b_addr = a; b_wdata = d; b_wmask = m;
    tick();
    b_en = 1'b0;
  endtask

  task automatic rd(input int k, input logic [6:0] a, input bit push, input logic [80:0] e);
    b_sel = k; b_en = 1'b1; b_wmode = 1'b0; b_addr = a;
    if (push) exp_q.push_back(e);
    tick();
    b_en = 1'b0;
  endtask

  task automatic wait_ready(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rdy_obs[k] && n < 400);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [80:0] ALL1  = 81'h1FFFFFFFFFFFFFFFFFFFF;
  localparam logic [80:0] HOLE  = 81'h1FFFFFFC0000007FFFFFF;

  initial begin
    int n;
    repeat (3) tick();

    // Init sweep on A with a read held on addr 5 the whole time.
    b_sel = 0; b_en = 1'b1; b_wmode = 1'b0; b_addr = 7'd5;
    rst_n = 3'b111;
    wait_ready(0, n);
    check("init_cycles_a", 81'(n), 81'd128);
    exp_q.push_back(81'd0);
    tick();
    b_en = 1'b0;
    repeat (2) tick();

    // Segment mask: clear only the middle 27 bits, then a no-op mask.
    wr(0, 7'd3, ALL1, 3'b111);
    wr(0, 7'd3, 81'd0, 3'b010);
    rd(0, 7'd3, 1'b1, HOLE);
    wr(0, 7'd3, 81'd0, 3'b000);
    rd(0, 7'd3, 1'b1, HOLE);
    repeat (2) tick();

    // rdata holds across a later write to the same address.
    wr(0, 7'd7, 81'h55, 3'b111);
    rd(0, 7'd7, 1'b1, 81'h55);
    tick();
    wr(0, 7'd7, 81'h99, 3'b111);
    repeat (2) tick();
    check("hold_after_write", rd_obs[0], 81'h55);
    rd(0, 7'd7, 1'b1, 81'h99);
    repeat (2) tick();

    // Output-register stream on B.
    wr(1, 7'd1, 81'h0A, 3'b001);
    wr(1, 7'd2, 81'h0B, 3'b001);
    wr(1, 7'd3, 81'h0C, 3'b001);
    rd(1, 7'd1, 1'b1, 81'h0A);
    rd(1, 7'd2, 1'b1, 81'h0B);
    rd(1, 7'd3, 1'b1, 81'h0C);
    repeat (3) tick();

    // Out-of-range on DEPTH=100.
    wr(1, 7'd99, 81'h3C, 3'b001);
    wr(1, 7'd100, 81'hFF, 3'b001);
    rd(1, 7'd100, 1'b1, 81'd0);
    rd(1, 7'd99, 1'b1, 81'h3C);
    rd(1, 7'd127, 1'b1, 81'd0);
    repeat (3) tick();

    // Reset between request and response, zero-init flavour.
    wr(1, 7'd5, 81'h77, 3'b001);
    rd(1, 7'd5, 1'b0, 81'd0);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    wait_ready(1, n);
    check("reinit_cycles_b", 81'(n), 81'd100);
    rd(1, 7'd5, 1'b1, 81'd0);
    rd(1, 7'd99, 1'b1, 81'd0);
    repeat (3) tick();

    // Same on C: contents survive reset and ready returns at once.
    wr(2, 7'd5, 81'h77, 3'b001);
    wr(2, 7'd9, 81'h12, 3'b001);
    rd(2, 7'd5, 1'b0, 81'd0);
    rst_n[2] = 1'b0;
    tick();
    rst_n[2] = 1'b1;
    wait_ready(2, n);
    check("reinit_cycles_c", 81'(n), 81'd1);
    rd(2, 7'd5, 1'b1, 81'h77);
    rd(2, 7'd9, 1'b1, 81'h12);
    repeat (4) tick();

    check("exp_q_drained", 81'(exp_q.size()), 81'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
